// File: rtl/ex_mem_alu_stage_if.sv
// ex_mem_alu_stage_if
//   Bundles the EX-stage inputs (ID/EX operands, ALU op, hazard-unit
//   enable/flush, control bits) and the EX/MEM latch outputs.
//   master : the upstream side that drives the i_* signals and observes the o_* signals
//   slave  : the execute stage, which consumes the i_* signals and drives the o_* signals
interface ex_mem_alu_stage_if #(
    parameter int NB_DATA   = 32,
    parameter int NB_ALU_OP = 4,
    parameter int NB_SHAMT  = 5,
    parameter int NB_REG    = 5
) ();
    logic                 i_enable;
    logic                 i_flush;
    logic                 i_valid;
    logic [NB_ALU_OP-1:0] i_alu_op;
    logic [NB_DATA-1:0]   i_data_a;
    logic [NB_DATA-1:0]   i_data_b;
    logic [NB_DATA-1:0]   i_store_data;
    logic [NB_SHAMT-1:0]  i_shamt;
    logic                 i_shift_var;
    logic [NB_REG-1:0]    i_write_reg;
    logic                 i_reg_write;
    logic                 i_mem_read;
    logic                 i_mem_write;

    logic                 o_valid;
    logic [NB_DATA-1:0]   o_alu_result;
    logic                 o_zero;
    logic                 o_branch_taken;
    logic [NB_DATA-1:0]   o_store_data;
    logic [NB_REG-1:0]    o_write_reg;
    logic                 o_reg_write;
    logic                 o_mem_read;
    logic                 o_mem_write;

    modport master (
        output i_enable, i_flush, i_valid, i_alu_op, i_data_a, i_data_b,
               i_store_data, i_shamt, i_shift_var, i_write_reg,
               i_reg_write, i_mem_read, i_mem_write,
        input  o_valid, o_alu_result, o_zero, o_branch_taken, o_store_data,
               o_write_reg, o_reg_write, o_mem_read, o_mem_write
    );

    modport slave (
        input  i_enable, i_flush, i_valid, i_alu_op, i_data_a, i_data_b,
               i_store_data, i_shamt, i_shift_var, i_write_reg,
               i_reg_write, i_mem_read, i_mem_write,
        output o_valid, o_alu_result, o_zero, o_branch_taken, o_store_data,
               o_write_reg, o_reg_write, o_mem_read, o_mem_write
    );
endinterface

// File: rtl/ex_mem_alu_stage.sv
// ex_mem_alu_stage
//   MIPS execute stage: ALU, zero flag and branch decision computed in one
//   cycle, then registered into the EX/MEM latch.
//   i_clk    : clock, all state updates on the rising edge
//   i_reset  : synchronous active-high reset (all outputs 0)
//   stage_if : slave side of ex_mem_alu_stage_if (operands, op, control, latch outputs)
//   Per-edge priority: reset > flush (bubble, zero=1) > enable (advance) > hold.
module ex_mem_alu_stage #(
    parameter int NB_DATA   = 32,
    parameter int NB_ALU_OP = 4,
    parameter int NB_SHAMT  = 5,
    parameter int NB_REG    = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    ex_mem_alu_stage_if.slave  stage_if
);

    localparam logic [NB_ALU_OP-1:0] OP_SLL = NB_ALU_OP'(4'h0);
    localparam logic [NB_ALU_OP-1:0] OP_SRL = NB_ALU_OP'(4'h1);
    localparam logic [NB_ALU_OP-1:0] OP_SRA = NB_ALU_OP'(4'h2);
    localparam logic [NB_ALU_OP-1:0] OP_ADD = NB_ALU_OP'(4'h3);
    localparam logic [NB_ALU_OP-1:0] OP_SUB = NB_ALU_OP'(4'h4);
    localparam logic [NB_ALU_OP-1:0] OP_AND = NB_ALU_OP'(4'h5);
    localparam logic [NB_ALU_OP-1:0] OP_OR  = NB_ALU_OP'(4'h6);
    localparam logic [NB_ALU_OP-1:0] OP_XOR = NB_ALU_OP'(4'h7);
    localparam logic [NB_ALU_OP-1:0] OP_NOR = NB_ALU_OP'(4'h8);
    localparam logic [NB_ALU_OP-1:0] OP_SLT = NB_ALU_OP'(4'h9);
    localparam logic [NB_ALU_OP-1:0] OP_LUI = NB_ALU_OP'(4'hD);
    localparam logic [NB_ALU_OP-1:0] OP_BEQ = NB_ALU_OP'(4'hE);
    localparam logic [NB_ALU_OP-1:0] OP_BNE = NB_ALU_OP'(4'hF);

    localparam int NB_HALF = NB_DATA / 2;

    logic [NB_SHAMT-1:0] shift_amt;
    logic [NB_DATA-1:0]  diff;
    logic                operands_equal;
    logic                branch_cond;
    logic [NB_DATA-1:0]  result_d;

    logic                valid_q,     valid_d;
    logic [NB_DATA-1:0]  result_q;
    logic                zero_q,      zero_d;
    logic                taken_q,     taken_d;
    logic [NB_DATA-1:0]  store_q;
    logic [NB_REG-1:0]   write_reg_q;
    logic                reg_write_q, reg_write_d;
    logic                mem_read_q,  mem_read_d;
    logic                mem_write_q, mem_write_d;

    // Variable shifts take the amount from the low bits of rs.
    assign shift_amt      = stage_if.i_shift_var ? stage_if.i_data_a[NB_SHAMT-1:0]
                                                 : stage_if.i_shamt;
    assign diff           = stage_if.i_data_a - stage_if.i_data_b;
    assign operands_equal = (stage_if.i_data_a == stage_if.i_data_b);

    always_comb begin
        result_d    = '0;
        branch_cond = 1'b0;
        unique case (stage_if.i_alu_op)
            OP_SLL: result_d = stage_if.i_data_b << shift_amt;
            OP_SRL: result_d = stage_if.i_data_b >> shift_amt;
            OP_SRA: result_d = $unsigned($signed(stage_if.i_data_b) >>> shift_amt);
            OP_ADD: result_d = stage_if.i_data_a + stage_if.i_data_b;
            OP_SUB: result_d = diff;
            OP_AND: result_d = stage_if.i_data_a & stage_if.i_data_b;
            OP_OR:  result_d = stage_if.i_data_a | stage_if.i_data_b;
            OP_XOR: result_d = stage_if.i_data_a ^ stage_if.i_data_b;
            OP_NOR: result_d = ~(stage_if.i_data_a | stage_if.i_data_b);
            OP_SLT: result_d = {{(NB_DATA-1){1'b0}},
                                ($signed(stage_if.i_data_a) < $signed(stage_if.i_data_b))};
            OP_LUI: result_d = {stage_if.i_data_b[NB_HALF-1:0], {NB_HALF{1'b0}}};
            OP_BEQ: begin
                result_d    = diff;
                branch_cond = operands_equal;
            end
            OP_BNE: begin
                result_d    = diff;
                branch_cond = ~operands_equal;
            end
            default: result_d = '0;
        endcase
    end

    // Zero flag uses the raw result; control bits are killed for bubbles.
    assign valid_d     = stage_if.i_valid;
    assign zero_d      = (result_d == '0);
    assign taken_d     = branch_cond           & stage_if.i_valid;
    assign reg_write_d = stage_if.i_reg_write  & stage_if.i_valid;
    assign mem_read_d  = stage_if.i_mem_read   & stage_if.i_valid;
    assign mem_write_d = stage_if.i_mem_write  & stage_if.i_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            taken_q     <= 1'b0;
            store_q     <= '0;
            write_reg_q <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (stage_if.i_flush) begin
            // Bubble: zero result, so the zero flag reads 1.
            valid_q     <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            taken_q     <= 1'b0;
            store_q     <= '0;
            write_reg_q <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (stage_if.i_enable) begin
            valid_q     <= valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            taken_q     <= taken_d;
            store_q     <= stage_if.i_store_data;
            write_reg_q <= stage_if.i_write_reg;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign stage_if.o_valid        = valid_q;
    assign stage_if.o_alu_result   = result_q;
    assign stage_if.o_zero         = zero_q;
    assign stage_if.o_branch_taken = taken_q;
    assign stage_if.o_store_data   = store_q;
    assign stage_if.o_write_reg    = write_reg_q;
    assign stage_if.o_reg_write    = reg_write_q;
    assign stage_if.o_mem_read     = mem_read_q;
    assign stage_if.o_mem_write    = mem_write_q;

endmodule

// File: tb/tb_ex_mem_alu_stage.sv
// tb_ex_mem_alu_stage
//   Scoreboard bench: the driver pushes the expected EX/MEM latch contents
//   for every edge it drives; the monitor pops one entry after each edge and
//   compares it with the DUT outputs.
module tb_ex_mem_alu_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic        zero;
        logic        taken;
        logic [31:0] store;
        logic [4:0]  wreg;
        logic        rw;
        logic        mr;
        logic        mw;
    } latch_t;

    logic i_clk;
    logic i_reset;

    ex_mem_alu_stage_if #(.NB_DATA(32), .NB_ALU_OP(4), .NB_SHAMT(5), .NB_REG(5)) bus ();

    ex_mem_alu_stage #(.NB_DATA(32), .NB_ALU_OP(4), .NB_SHAMT(5), .NB_REG(5)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .stage_if (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    latch_t exp_q[$];
    latch_t model;
    int     n_cmp = 0;
    int     n_bad = 0;

    // Reference ALU written straight from the op-code table.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int s);
        case (op)
            4'h0: return b << s;
            4'h1: return b >> s;
            4'h2: return $unsigned($signed(b) >>> s);
            4'h3: return a + b;
            4'h4: return a - b;
            4'h5: return a & b;
            4'h6: return a | b;
            4'h7: return a ^ b;
            4'h8: return ~(a | b);
            4'h9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hD: return {b[15:0], 16'h0000};
            4'hE: return a - b;
            4'hF: return a - b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input logic rst, input logic fl, input logic en, input logic v,
                        input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] sd, input logic [4:0] sh, input logic shv,
                        input logic [4:0] wr, input logic rw, input logic mr, input logic mw);
        int          s;
        logic [31:0] r;
        logic        br;
        @(negedge i_clk);
        i_reset           = rst;
        bus.i_flush       = fl;
        bus.i_enable      = en;
        bus.i_valid       = v;
        bus.i_alu_op      = op;
        bus.i_data_a      = a;
        bus.i_data_b      = b;
        bus.i_store_data  = sd;
        bus.i_shamt       = sh;
        bus.i_shift_var   = shv;
        bus.i_write_reg   = wr;
        bus.i_reg_write   = rw;
        bus.i_mem_read    = mr;
        bus.i_mem_write   = mw;

        s  = shv ? int'(a % 32) : int'(sh);
        r  = ref_alu(op, a, b, s);
        br = (op == 4'hE && a == b) || (op == 4'hF && a != b);
        if (rst) begin
            model = '0;
        end else if (fl) begin
            model      = '0;
            model.zero = 1'b1;
        end else if (en) begin
            model.valid  = v;
            model.result = r;
            model.zero   = (r == 32'd0);
            model.taken  = br && v;
            model.store  = sd;
            model.wreg   = wr;
            model.rw     = rw && v;
            model.mr     = mr && v;
            model.mw     = mw && v;
        end
        exp_q.push_back(model);
    endtask

    // Plain enabled instruction.
    task automatic issue(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic shv);
        step(1'b0, 1'b0, 1'b1, v, op, a, b, 32'h0, sh, shv, 5'd3, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        latch_t e;
        latch_t act;
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = '{bus.o_valid, bus.o_alu_result, bus.o_zero, bus.o_branch_taken,
                        bus.o_store_data, bus.o_write_reg, bus.o_reg_write,
                        bus.o_mem_read, bus.o_mem_write};
                n_cmp++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL ex_mem_latch t=%0t actual v=%b r=%h z=%b t=%b sd=%h wr=%0d rw=%b mr=%b mw=%b required v=%b r=%h z=%b t=%b sd=%h wr=%0d rw=%b mr=%b mw=%b",
                             $time, act.valid, act.result, act.zero, act.taken, act.store,
                             act.wreg, act.rw, act.mr, act.mw, e.valid, e.result, e.zero,
                             e.taken, e.store, e.wreg, e.rw, e.mr, e.mw);
                end
            end
        end
    end

    initial begin : stimulus
        logic        rst, fl, en, v, shv;
        logic [3:0]  op;
        logic [31:0] a, b;
        int          wait_cyc;

        model            = '0;
        i_reset          = 1'b1;
        bus.i_flush      = 1'b0;
        bus.i_enable     = 1'b0;
        bus.i_valid      = 1'b0;
        bus.i_alu_op     = '0;
        bus.i_data_a     = '0;
        bus.i_data_b     = '0;
        bus.i_store_data = '0;
        bus.i_shamt      = '0;
        bus.i_shift_var  = 1'b0;
        bus.i_write_reg  = '0;
        bus.i_reg_write  = 1'b0;
        bus.i_mem_read   = 1'b0;
        bus.i_mem_write  = 1'b0;

        // Reset, then the directed sequence.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 4'h3, 32'h7FFF_FFFF, 32'h1,          5'd0, 1'b0);
        issue(1'b1, 4'h2, 32'h0,         32'h8000_0010,  5'd4, 1'b0);
        issue(1'b1, 4'h1, 32'h0000_0021, 32'h8000_0010,  5'd9, 1'b1);
        issue(1'b1, 4'h9, 32'hFFFF_FFFF, 32'h1,          5'd0, 1'b0);
        issue(1'b1, 4'hD, 32'h0,         32'h0000_1234,  5'd0, 1'b0);
        issue(1'b1, 4'hE, 32'h55,        32'h55,         5'd0, 1'b0);
        issue(1'b1, 4'hF, 32'h55,        32'h55,         5'd0, 1'b0);
        issue(1'b0, 4'hE, 32'h55,        32'h55,         5'd0, 1'b0);
        issue(1'b1, 4'hB, 32'h1234,      32'h5678,       5'd0, 1'b0);
        // SW, stall three cycles, then flush while stalled.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 32'h100, 32'h8, 32'hDEAD_BEEF, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 32'h9, 32'h3, 32'h1111_1111, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 32'h9, 32'h3, 32'h1111_1111, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
        // Reset overriding enable+flush+valid ADD, then a normal ADD.
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 32'h5, 32'h6, 32'h77, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 32'h5, 32'h6, 32'h77, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 31) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            en  = ($urandom_range(0, 3) != 0);
            v   = ($urandom_range(0, 3) != 0);
            shv = $urandom_range(0, 1) != 0;
            op  = 4'($urandom_range(0, 15));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = {$urandom_range(0, 1) != 0, 31'($urandom_range(0, 3))};
                default: b = $urandom;
            endcase
            step(rst, fl, en, v, op, a, b, $urandom, 5'($urandom_range(0, 31)), shv,
                 5'($urandom_range(0, 31)), $urandom_range(0, 1) != 0,
                 $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(negedge i_clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain actual %0d entries left required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
